// File: rtl/fifo_status_if.sv
// fifo_status_if: strobes, thresholds and status flags between the FIFO datapath and the switch control FSM.
interface fifo_status_if;
  logic       init;
  logic [2:0] afMF, aeMF, afVC, aeVC, afD, aeD;
  logic [4:0] push, pop;
  logic [4:0] FIFO_empties, FIFO_errors, almost_full, almost_empty;
  logic       cfg_valid;
  modport master (
    output init, afMF, aeMF, afVC, aeVC, afD, aeD, push, pop,
    input  FIFO_empties, FIFO_errors, almost_full, almost_empty, cfg_valid
  );
  modport slave (
    input  init, afMF, aeMF, afVC, aeVC, afD, aeD, push, pop,
    output FIFO_empties, FIFO_errors, almost_full, almost_empty, cfg_valid
  );
endinterface

// File: rtl/fifo_status_monitor.sv
// fifo_status_monitor: occupancy, sticky error and almost-full/empty flags for the MF, VC0, VC1, D0 and D1 FIFOs.
module fifo_status_monitor #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4,
  parameter int AF_RST = 6,
  parameter int AE_RST = 3
) (
  input logic          clk,
  input logic          reset_L,
  fifo_status_if.slave s
);
  typedef enum logic {UNCFG, CFG} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [2:0]       af_q [3];
  logic [2:0]       af_d [3];
  logic [2:0]       ae_q [3];
  logic [2:0]       ae_d [3];
  logic [4:0]       err_q, err_d, emp, full, inc, dec;
  // Threshold slot per FIFO: MF alone, the two VCs share one, the two Ds share one.
  function automatic logic [1:0] cls(int i);
    return i == 0 ? 2'd0 : i < 3 ? 2'd1 : 2'd2;
  endfunction
  always_comb begin
    emp            = '0;
    full           = '0;
    s.almost_full  = '0;
    s.almost_empty = '0;
    for (int i = 0; i < 5; i++) begin
      emp[i]            = cnt_q[i] == '0;
      full[i]           = cnt_q[i] == CNT_W'(DEPTH);
      s.almost_full[i]  = cnt_q[i] >= CNT_W'(af_q[cls(i)]);
      s.almost_empty[i] = cnt_q[i] <= CNT_W'(ae_q[cls(i)]);
    end
    s.FIFO_empties = emp;
    s.FIFO_errors  = err_q;
    s.cfg_valid    = state_q == CFG;
  end
  always_comb begin
    state_d = s.init ? CFG : state_q;
    af_d    = af_q;
    ae_d    = ae_q;
    if (s.init) begin
      af_d = '{s.afMF, s.afVC, s.afD};
      ae_d = '{s.aeMF, s.aeVC, s.aeD};
    end
    // A push into an empty FIFO always lands, even with a simultaneous (ignored) pop.
    inc   = s.push & ~full & (~s.pop | emp);
    dec   = s.pop & ~s.push & ~emp;
    err_d = (s.init ? 5'b0 : err_q) | (s.push & ~s.pop & full) | (s.pop & emp);
    cnt_d = cnt_q;
    for (int i = 0; i < 5; i++)
      cnt_d[i] = inc[i] ? cnt_q[i] + CNT_W'(1) : dec[i] ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= UNCFG;
      cnt_q   <= '{default: '0};
      err_q   <= '0;
      af_q    <= '{default: 3'(AF_RST)};
      ae_q    <= '{default: 3'(AE_RST)};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  end
endmodule

// File: tb/tb_fifo_status_monitor.sv
// tb_fifo_status_monitor: directed scenarios plus biased random traffic against an occupancy model.
module tb_fifo_status_monitor;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  fifo_status_if bus();
  fifo_status_monitor dut (.clk(clk), .reset_L(reset_L), .s(bus));
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  int cnt [5];
  int af [3];
  int ae [3];
  bit [4:0] err;
  bit cfg;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic int slot(int i);
    return i == 0 ? 0 : (i < 3 ? 1 : 2);
  endfunction
  task automatic model_reset();
    foreach (cnt[i]) cnt[i] = 0;
    af = '{6, 6, 6};
    ae = '{3, 3, 3};
    err = '0;
    cfg = 1'b0;
  endtask
  task automatic check_all(string tag);
    logic [4:0] e, f, a;
    for (int i = 0; i < 5; i++) begin
      e[i] = cnt[i] == 0;
      f[i] = cnt[i] >= af[slot(i)];
      a[i] = cnt[i] <= ae[slot(i)];
    end
    chk({tag, ".empties"}, 32'(bus.FIFO_empties), 32'(e));
    chk({tag, ".errors"}, 32'(bus.FIFO_errors), 32'(err));
    chk({tag, ".afull"}, 32'(bus.almost_full), 32'(f));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(a));
    chk({tag, ".cfg"}, 32'(bus.cfg_valid), 32'(cfg));
  endtask
  task automatic set_thr(int amf, int emf, int avc, int evc, int ad, int ed);
    bus.afMF = 3'(amf); bus.aeMF = 3'(emf);
    bus.afVC = 3'(avc); bus.aeVC = 3'(evc);
    bus.afD  = 3'(ad);  bus.aeD  = 3'(ed);
  endtask
  task automatic step(logic [4:0] p, logic [4:0] q, logic in, string tag);
    bit [4:0] ev;
    bus.push = p; bus.pop = q; bus.init = in;
    @(posedge clk);
    ev = '0;
    for (int i = 0; i < 5; i++) begin
      if (p[i] && !q[i]) begin
        if (cnt[i] < 8) cnt[i]++; else ev[i] = 1'b1;
      end else if (q[i] && !p[i]) begin
        if (cnt[i] > 0) cnt[i]--; else ev[i] = 1'b1;
      end else if (p[i] && q[i] && cnt[i] == 0) begin
        cnt[i] = 1; ev[i] = 1'b1;
      end
    end
    err = (in ? 5'b0 : err) | ev;
    if (in) begin
      af = '{int'(bus.afMF), int'(bus.afVC), int'(bus.afD)};
      ae = '{int'(bus.aeMF), int'(bus.aeVC), int'(bus.aeD)};
      cfg = 1'b1;
    end
    #1;
    bus.push = '0; bus.pop = '0; bus.init = 1'b0;
    check_all(tag);
  endtask
  task automatic async_reset(string tag);
    #3 reset_L = 1'b0;
    #1 model_reset();
    check_all(tag);
    #2 reset_L = 1'b1;
  endtask
  initial begin
    bus.push = '0; bus.pop = '0; bus.init = 1'b0;
    set_thr(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    reset_L = 1'b1;
    @(posedge clk);
    #1 check_all("idle");
    set_thr(6, 3, 6, 3, 6, 3);
    step('0, '0, 1'b1, "init");
    repeat (6) step(5'b00001, '0, 1'b0, "mf_push");
    repeat (9) step(5'b00010, '0, 1'b0, "vc0_ovf");
    step('0, '0, 1'b0, "vc0_sticky");
    step('0, '0, 1'b1, "init_clr");
    step('0, 5'b10000, 1'b0, "d1_unf");
    repeat (6) step('0, 5'b00001, 1'b0, "mf_pop");
    step(5'b00001, 5'b00001, 1'b0, "mf_pp_empty");
    repeat (8) step(5'b00100, '0, 1'b0, "vc1_fill");
    step(5'b00100, 5'b00100, 1'b0, "vc1_pp_full");
    set_thr(6, 3, 7, 1, 6, 3);
    step('0, '0, 1'b1, "init_relatch");
    step(5'b00010, 5'b00001, 1'b1, "init_vs_err");
    async_reset("async_rst");
    step('0, '0, 1'b0, "post_rst");
    for (int k = 0; k < 500; k++) begin
      logic [4:0] p, q;
      logic in;
      bit fill;
      fill = ((k / 30) % 2) == 0;
      for (int i = 0; i < 5; i++) begin
        p[i] = $urandom_range(0, 99) < (fill ? 70 : 25);
        q[i] = $urandom_range(0, 99) < (fill ? 25 : 70);
      end
      in = $urandom_range(0, 99) < 4;
      if (in) set_thr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      step(p, q, in, "rnd");
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
